// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone constants and responder state encoding
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BURST,
        ST_GAP
    } state_t;

endpackage

// File: rtl/wb_bram_bytewr.sv
// rtl/wb_bram_bytewr.sv - single-port synchronous RAM, byte write enables, write-first
module wb_bram_bytewr
    import wb_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic                 clk,
    input  logic [SEL_W-1:0]     we,
    input  logic [adr_width-1:0] adr,
    input  logic [DATA_W-1:0]    wdat,
    output logic [DATA_W-1:0]    rdat
);

    logic [DATA_W-1:0] mem [0:(2**adr_width)-1];

    // Written lanes return the new byte on the same edge; other lanes return stored data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SEL_W; i++) begin
            if (we[i]) begin
                mem[adr][8*i +: 8] <= wdat[8*i +: 8];
                rdat[8*i +: 8]     <= wdat[8*i +: 8];
            end else begin
                rdat[8*i +: 8]     <= mem[adr][8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_bram_responder.sv
// rtl/wb_bram_responder.sv - Wishbone B3 slave over byte-writable RAM with wait states and bursts
module wb_bram_responder
    import wb_pkg::*;
#(
    parameter int adr_width   = 11,
    parameter int wait_states = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [31:0]       wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic [2:0]        wb_cti_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o
);

    localparam logic [3:0] WS = 4'(wait_states);

    state_t                 state_q, state_d;
    logic [adr_width-1:0]   adr_q, adr_d, bus_adr, ram_adr;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rdy_q;
    logic                   write_beat;
    logic [SEL_W-1:0]       ram_we;
    logic [DATA_W-1:0]      ram_rdat;
    logic                   unused_adr;

    assign bus_adr    = wb_adr_i[adr_width+1:2];
    assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

    // rdy_q: RAM output holds the word at adr_q; lost only when the port was used for a write.
    always_comb begin
        wb_ack_o = 1'b0;
        case (state_q)
            ST_ACK:   wb_ack_o = wb_cyc_i;
            ST_BURST: wb_ack_o = wb_cyc_i & wb_stb_i & (wb_we_i | rdy_q);
            default:  wb_ack_o = 1'b0;
        endcase
    end

    assign write_beat = wb_ack_o & wb_we_i;
    assign ram_we     = {SEL_W{write_beat}} & wb_sel_i;
    assign wb_dat_o   = wb_ack_o ? ram_rdat : '0;

    // A read beat prefetches the next word; a write beat or a stall keeps the port on adr_q.
    always_comb begin
        ram_adr = adr_q;
        if (state_q == ST_IDLE) begin
            ram_adr = bus_adr;
        end else if ((state_q == ST_ACK || state_q == ST_BURST) && wb_ack_o && !wb_we_i) begin
            ram_adr = adr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d = bus_adr;
                    if (WS != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_q <= 4'd1) state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (wb_cti_i == CTI_INCR && wb_stb_i) begin
                    state_d = ST_BURST;
                    adr_d   = adr_q + 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_BURST: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (wb_ack_o) begin
                    adr_d = adr_q + 1'b1;
                    if (wb_cti_i != CTI_INCR) state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= 4'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            rdy_q   <= !write_beat;
        end
    end

    wb_bram_bytewr #(
        .adr_width(adr_width)
    ) u_ram (
        .clk  (sys_clk),
        .we   (ram_we),
        .adr  (ram_adr),
        .wdat (wb_dat_i),
        .rdat (ram_rdat)
    );

endmodule

// File: tb/tb_wb_bram_responder.sv
// tb/tb_wb_bram_responder.sv - scoreboard bench for wb_bram_responder (wait_states 0 and 3)
module tb_wb_bram_responder;
    import wb_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        bit          chk;
    } exp_t;

    logic        clk, rst_n;
    logic [31:0] adr, dat_w, dat0, dat3;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we, stb, cyc0, cyc3, ack0, ack3;
    int          cycle_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[2][$];
    exp_t        mon_e;
    logic [1:0]  acks;
    logic [31:0] dats [2];
    logic [31:0] v [4];

    assign acks    = {ack3, ack0};
    assign dats[0] = dat0;
    assign dats[1] = dat3;

    wb_bram_responder #(.adr_width(11), .wait_states(0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat0),
        .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_ack_o(ack0)
    );

    wb_bram_responder #(.adr_width(11), .wait_states(3)) dut3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat3),
        .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_ack_o(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (acks[d]) begin
                checks++;
                if (q[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack dut%0d cycle %0d data %h", d, cycle_cnt, dats[d]);
                end else begin
                    mon_e = q[d].pop_front();
                    if (mon_e.cyc != cycle_cnt || (mon_e.chk && dats[d] !== mon_e.dat)) begin
                        errors++;
                        $display("FAIL ack_beat dut%0d cycle got %0d exp %0d data got %h exp %h",
                                 d, cycle_cnt, mon_e.cyc, dats[d], mon_e.dat);
                    end
                end
            end else if (q[d].size() > 0 && q[d][0].cyc <= cycle_cnt) begin
                mon_e = q[d].pop_front();
                checks++;
                errors++;
                $display("FAIL missing_ack dut%0d cycle got none exp %0d data exp %h", d, mon_e.cyc, mon_e.dat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cycle_cnt);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
    endtask

    task automatic drive(input int d, input logic w, input logic [31:0] word, input logic [31:0] wd,
                         input logic [3:0] sl, input logic [2:0] ct);
        cyc0 = (d == 0); cyc3 = (d == 1); stb = 1'b1; we = w;
        adr = word << 2; dat_w = wd; sel = sl; cti = ct;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic classic(input int d, input logic w, input logic [31:0] word, input logic [31:0] wd,
                           input logic [3:0] sl, input logic [31:0] ex);
        int ws;
        ws = (d == 0) ? 0 : 3;
        drive(d, w, word, wd, sl, CTI_CLASSIC);
        q[d].push_back(exp_t'{cycle_cnt + 1 + ws, ex, !w});
        repeat (ws + 2) step();
        idle();
        step();
    endtask

    task automatic burst(input logic w, input logic [31:0] start, input logic [31:0] bv [4],
                         input int stall_at, input int stall_len);
        drive(0, w, start, bv[0], 4'hF, CTI_INCR);
        q[0].push_back(exp_t'{cycle_cnt + 1, bv[0], !w});
        step();
        step();
        for (int i = 1; i < 4; i++) begin
            if (i == stall_at) begin
                stb = 1'b0;
                repeat (stall_len) step();
            end
            drive(0, w, start + i, bv[i], 4'hF, (i == 3) ? CTI_EOB : CTI_INCR);
            q[0].push_back(exp_t'{cycle_cnt, bv[i], !w});
            step();
        end
        idle();
        step();
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0;
        idle();
        repeat (3) step();
        check("reset_ack0", {31'd0, ack0}, 32'd0);
        check("reset_dat0", dat0, 32'd0);
        check("reset_ack3", {31'd0, ack3}, 32'd0);
        check("reset_dat3", dat3, 32'd0);
        rst_n = 1'b1;
        step();

        classic(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0);
        classic(0, 1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADBEEF);

        classic(0, 1'b1, 32'h020, 32'hAABBCCDD, 4'hF, 32'h0);
        classic(0, 1'b1, 32'h020, 32'h00000011, 4'b0001, 32'h0);
        classic(0, 1'b0, 32'h020, 32'h0, 4'hF, 32'hAABBCC11);
        classic(0, 1'b1, 32'h020, 32'hFFFFFFFF, 4'b0000, 32'h0);
        classic(0, 1'b0, 32'h020, 32'h0, 4'hF, 32'hAABBCC11);
        classic(0, 1'b1, 32'h020, 32'h99887766, 4'b0100, 32'h0);
        classic(0, 1'b0, 32'h020, 32'h0, 4'hF, 32'hAA88CC11);

        v = '{32'h100, 32'h101, 32'h102, 32'h103};
        burst(1'b1, 32'h100, v, 0, 0);
        burst(1'b0, 32'h100, v, 0, 0);
        burst(1'b0, 32'h100, v, 2, 2);

        classic(0, 1'b1, 32'h000, 32'h0000C000, 4'hF, 32'h0);
        classic(0, 1'b1, 32'h001, 32'h0000C001, 4'hF, 32'h0);
        classic(0, 1'b1, 32'h7FE, 32'h000007FE, 4'hF, 32'h0);
        classic(0, 1'b1, 32'h7FF, 32'h000007FF, 4'hF, 32'h0);
        v = '{32'h7FE, 32'h7FF, 32'hC000, 32'hC001};
        burst(1'b0, 32'h7FE, v, 0, 0);

        classic(1, 1'b1, 32'h005, 32'h12345678, 4'hF, 32'h0);
        classic(1, 1'b0, 32'h005, 32'h0, 4'hF, 32'h12345678);
        drive(1, 1'b0, 32'h005, 32'h0, 4'hF, CTI_CLASSIC);
        step();
        step();
        idle();
        step();
        classic(1, 1'b0, 32'h005, 32'h0, 4'hF, 32'h12345678);

        classic(0, 1'b1, 32'h202, 32'h00000055, 4'hF, 32'h0);
        drive(0, 1'b1, 32'h200, 32'hA0, 4'hF, CTI_INCR);
        q[0].push_back(exp_t'{cycle_cnt + 1, 32'h0, 1'b0});
        step();
        step();
        drive(0, 1'b1, 32'h201, 32'hA1, 4'hF, CTI_INCR);
        q[0].push_back(exp_t'{cycle_cnt, 32'h0, 1'b0});
        step();
        drive(0, 1'b1, 32'h202, 32'hA2, 4'hF, CTI_INCR);
        rst_n = 1'b0;
        #1;
        check("async_reset_ack", {31'd0, ack0}, 32'd0);
        check("async_reset_dat", dat0, 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();
        classic(0, 1'b0, 32'h201, 32'h0, 4'hF, 32'h000000A1);
        classic(0, 1'b0, 32'h202, 32'h0, 4'hF, 32'h00000055);

        repeat (4) step();
        check("queue0_drained", q[0].size(), 32'd0);
        check("queue3_drained", q[1].size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
